// File: rtl/upower_mem_arbiter.sv
// uPOWER shared-memory arbiter.
// Three requesters (data, fetch, debug) share one single-port memory.
// Each access is sequenced IDLE -> ACCESS -> (WAIT -> RESP for reads).
// Debug has fixed top priority. Data beats fetch unless fetch has lost
// STARVE_MAX arbitrations in a row, in which case fetch is promoted.

module upower_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 64,
    parameter int MEM_LAT    = 1,   // legal range 1..4
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    output logic [2:0]      gnt,
    output logic [2:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    // Starve counter only ever needs to reach STARVE_MAX.
    localparam int              SW         = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [2:0]      LAT_INIT   = 3'(MEM_LAT);

    localparam logic [1:0] ID_DATA  = 2'd0;
    localparam logic [1:0] ID_FETCH = 2'd1;
    localparam logic [1:0] ID_DEBUG = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } stateT;

    stateT          state;
    logic [SW-1:0]  starve;
    logic [2:0]     waitCnt;
    logic [1:0]     winner;
    logic           latchWe;

    logic [1:0]     pick;
    logic           anyReq;

    assign anyReq = |req;

    // Winner selection for the current arbitration cycle.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves pick
        // unassigned; a missing default here would infer a latch.
        pick = ID_DATA;
        if (req[2]) begin
            pick = ID_DEBUG;
        end else if (req[1] && (!req[0] || starve == STARVE_TOP)) begin
            pick = ID_FETCH;
        end
    end

    // Sequencer: state, starve counter, latches and all registered outputs.
    // The latched address and write data live directly in mem_addr and
    // mem_wdata, which must hold their values between accesses anyway.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            starve    <= '0;
            waitCnt   <= '0;
            winner    <= '0;
            latchWe   <= 1'b0;
            gnt       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // NOTE: every state register uses non-blocking assignment so all
            // of them update together at the edge, independent of statement
            // order in this block.
            gnt    <= '0;
            rvalid <= '0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;

            case (state)
                // RESP shares IDLE's arbitration so reads can run back to back.
                IDLE, RESP: begin
                    if (!req[1] || pick == ID_FETCH) begin
                        starve <= '0;
                    end else if (starve != STARVE_TOP) begin
                        starve <= starve + 1'b1;
                    end

                    if (anyReq) begin
                        winner    <= pick;
                        latchWe   <= we[pick];
                        mem_addr  <= addr[int'(pick)*AW +: AW];
                        mem_wdata <= wdata[int'(pick)*DW +: DW];
                        gnt       <= 3'b001 << pick;
                        mem_en    <= 1'b1;
                        mem_we    <= we[pick];
                        state     <= ACCESS;
                    end else begin
                        state     <= IDLE;
                    end
                end

                // Strobe cycle; writes are finished once it has been issued.
                ACCESS: begin
                    if (latchWe) begin
                        state   <= IDLE;
                    end else begin
                        waitCnt <= LAT_INIT;
                        state   <= WAIT;
                    end
                end

                // Count down to the cycle in which mem_rdata is valid.
                WAIT: begin
                    waitCnt <= waitCnt - 1'b1;
                    if (waitCnt == 3'd1) begin
                        rdata  <= mem_rdata;
                        rvalid <= 3'b001 << winner;
                        state  <= RESP;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_upower_mem_arbiter.sv
// Testbench for upower_mem_arbiter.
// Two arbiter instances: lane 0 with MEM_LAT=1, lane 1 with MEM_LAT=3.
// Each lane has its own memory model preloaded with mem[i]=i. Stimulus
// pushes expected grants and read responses into per-lane queues, and a
// per-lane monitor pops and compares whenever gnt or rvalid is seen.

module tb_upower_mem_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int LANES = 2;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [2:0]    oneHot;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } expT;

    logic            clk;
    logic            reset;
    logic [2:0]      reqV      [LANES];
    logic [2:0]      weV       [LANES];
    logic [3*AW-1:0] addrV     [LANES];
    logic [3*DW-1:0] wdataV    [LANES];
    logic [2:0]      gntV      [LANES];
    logic [2:0]      rvalidV   [LANES];
    logic [DW-1:0]   rdataV    [LANES];
    logic            memEnV    [LANES];
    logic            memWeV    [LANES];
    logic [AW-1:0]   memAddrV  [LANES];
    logic [DW-1:0]   memWdataV [LANES];
    logic [DW-1:0]   memRdataV [LANES];
    logic            busyV     [LANES];

    expT gntQ [LANES][$];
    expT rspQ [LANES][$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    for (genvar g = 0; g < LANES; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic [DW-1:0] mem      [1024];
        logic [DW-1:0] pipeData [4];
        logic [3:0]    pipeVld;

        upower_mem_arbiter #(
            .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(4)
        ) dut (
            .clk(clk),
            .reset(reset),
            .req(reqV[g]),
            .we(weV[g]),
            .addr(addrV[g]),
            .wdata(wdataV[g]),
            .gnt(gntV[g]),
            .rvalid(rvalidV[g]),
            .rdata(rdataV[g]),
            .mem_en(memEnV[g]),
            .mem_we(memWeV[g]),
            .mem_addr(memAddrV[g]),
            .mem_wdata(memWdataV[g]),
            .mem_rdata(memRdataV[g]),
            .busy(busyV[g])
        );

        // Read data is only meaningful in the cycle ACCESS + LAT; poison otherwise.
        assign memRdataV[g] = pipeVld[LAT-1] ? pipeData[LAT-1] : 64'hBAD0_BAD0_BAD0_BAD0;

        // Memory model: synchronous write, LAT-stage read pipeline.
        initial begin : memModel
            for (int i = 0; i < 1024; i++) mem[i] = 64'(i);
            for (int i = 0; i < 4; i++) pipeData[i] = '0;
            pipeVld = '0;
            forever begin
                @(posedge clk);
                if (memEnV[g] && memWeV[g]) mem[memAddrV[g]] <= memWdataV[g];
                for (int i = 3; i > 0; i--) pipeData[i] <= pipeData[i-1];
                pipeData[0] <= mem[memAddrV[g]];
                pipeVld     <= {pipeVld[2:0], memEnV[g] && !memWeV[g]};
            end
        end

        // Monitor: compare every grant and response against the queues.
        initial begin : monitor
            expT e;
            forever begin
                @(negedge clk);
                if (!reset) begin
                    check($sformatf("lane%0d mem_en vs gnt", g), 128'(memEnV[g]), 128'(|gntV[g]));
                    if (|gntV[g]) begin
                        if (gntQ[g].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL lane%0d unexpected gnt: actual=%b required=none (cycle %0d)", g, gntV[g], cyc);
                        end else begin
                            e = gntQ[g].pop_front();
                            check($sformatf("lane%0d gnt", g),
                                  128'({32'(cyc), gntV[g], memEnV[g], memWeV[g], memAddrV[g], memWdataV[g]}),
                                  128'({e.cyc, e.oneHot, 1'b1, e.we, e.addr, e.data}));
                        end
                    end
                    if (|rvalidV[g]) begin
                        if (rspQ[g].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL lane%0d unexpected rvalid: actual=%b required=none (cycle %0d)", g, rvalidV[g], cyc);
                        end else begin
                            e = rspQ[g].pop_front();
                            check($sformatf("lane%0d rvalid", g),
                                  128'({32'(cyc), rvalidV[g], rdataV[g]}),
                                  128'({e.cyc, e.oneHot, e.data}));
                        end
                    end
                end
            end
        end
    end

    task automatic waitUntil(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic expGnt(input int l, input int c, input int r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        expT e;
        e.cyc    = 32'(c);
        e.oneHot = 3'(3'b001 << r);
        e.we     = w;
        e.addr   = a;
        e.data   = d;
        gntQ[l].push_back(e);
    endtask

    task automatic expRsp(input int l, input int c, input int r, input logic [DW-1:0] d);
        expT e;
        e.cyc    = 32'(c);
        e.oneHot = 3'(3'b001 << r);
        e.we     = 1'b0;
        e.addr   = '0;
        e.data   = d;
        rspQ[l].push_back(e);
    endtask

    // Requester: present a request and hold it until n grants have been seen.
    task automatic request(input int l, input int r, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int n);
        int seen;
        int budget;
        seen   = 0;
        budget = 0;
        weV[l][r]               = w;
        addrV[l][r*AW +: AW]    = a;
        wdataV[l][r*DW +: DW]   = d;
        reqV[l][r]              = 1'b1;
        while (seen < n && budget < 200) begin
            @(negedge clk);
            budget++;
            if (gntV[l][r]) seen++;
        end
        reqV[l][r] = 1'b0;
        check($sformatf("lane%0d req%0d grant count", l, r), 128'(seen), 128'(n));
    endtask

    task automatic checkIdle(input int l, input string name);
        check({name, " ctrl"}, 128'({gntV[l], rvalidV[l], memEnV[l], memWeV[l], busyV[l], memAddrV[l]}), 128'(0));
        check({name, " data"}, 128'({rdataV[l], memWdataV[l]}), 128'(0));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t;
        int order5 [10];
        int base5  [3];

        reset = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            reqV[l] = '0; weV[l] = '0; addrV[l] = '0; wdataV[l] = '0;
        end
        repeat (2) @(negedge clk);
        checkIdle(0, "lane0 in reset");
        checkIdle(1, "lane1 in reset");
        reset = 1'b0;
        @(negedge clk);
        checkIdle(0, "lane0 after reset");

        // Test 1: fetch read of addr 5, MEM_LAT=1.
        @(negedge clk);
        t = cyc;
        expGnt(0, t + 1, 1, 1'b0, 10'd5, '0);
        expRsp(0, t + 3, 1, 64'd5);
        fork
            request(0, 1, 1'b0, 10'd5, '0, 1);
            begin
                check("t1 busy c0", 128'(busyV[0]), 128'(0));
                waitUntil(t + 1);
                check("t1 busy c1", 128'(busyV[0]), 128'(1));
                waitUntil(t + 2);
                check("t1 busy c2", 128'(busyV[0]), 128'(1));
                check("t1 mem_en c2", 128'(memEnV[0]), 128'(0));
                check("t1 mem_addr hold", 128'(memAddrV[0]), 128'(5));
                waitUntil(t + 4);
                check("t1 busy c4", 128'(busyV[0]), 128'(0));
                waitUntil(t + 5);
                check("t1 rdata hold", 128'(rdataV[0]), 128'(5));
            end
        join

        // Test 2: data write of 99 to addr 3, then read it back.
        @(negedge clk);
        t = cyc;
        expGnt(0, t + 1, 0, 1'b1, 10'd3, 64'd99);
        fork
            request(0, 0, 1'b1, 10'd3, 64'd99, 1);
            begin
                waitUntil(t + 2);
                check("t2 write two cycles", 128'(busyV[0]), 128'(0));
                check("t2 rdata kept", 128'(rdataV[0]), 128'(5));
            end
        join
        waitUntil(t + 5);
        t = cyc;
        expGnt(0, t + 1, 0, 1'b0, 10'd3, '0);
        expRsp(0, t + 3, 0, 64'd99);
        request(0, 0, 1'b0, 10'd3, '0, 1);
        waitUntil(t + 6);

        // Test 3: all three read together: debug, then data, then fetch.
        t = cyc;
        expGnt(0, t + 1, 2, 1'b0, 10'd12, '0);
        expRsp(0, t + 3, 2, 64'd12);
        expGnt(0, t + 4, 0, 1'b0, 10'd10, '0);
        expRsp(0, t + 6, 0, 64'd10);
        expGnt(0, t + 7, 1, 1'b0, 10'd11, '0);
        expRsp(0, t + 9, 1, 64'd11);
        fork
            request(0, 0, 1'b0, 10'd10, '0, 1);
            request(0, 1, 1'b0, 10'd11, '0, 1);
            request(0, 2, 1'b0, 10'd12, '0, 1);
        join
        waitUntil(t + 12);

        // Test 4: data and fetch continuous: four data grants, then fetch.
        t = cyc;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) begin
                expGnt(0, t + 1 + 3*k, 1, 1'b0, 10'd30, '0);
                expRsp(0, t + 3 + 3*k, 1, 64'd30);
            end else begin
                expGnt(0, t + 1 + 3*k, 0, 1'b0, 10'd20, '0);
                expRsp(0, t + 3 + 3*k, 0, 64'd20);
            end
        end
        fork
            request(0, 0, 1'b0, 10'd20, '0, 8);
            request(0, 1, 1'b0, 10'd30, '0, 2);
        join
        waitUntil(t + 33);

        // Test 5: fetch starved, then debug arrives and still wins first.
        t = cyc;
        order5 = '{0, 0, 0, 0, 2, 2, 2, 1, 0, 0};
        base5  = '{21, 31, 41};
        for (int k = 0; k < 10; k++) begin
            expGnt(0, t + 1 + 3*k, order5[k], 1'b0, AW'(base5[order5[k]]), '0);
            expRsp(0, t + 3 + 3*k, order5[k], 64'(base5[order5[k]]));
        end
        fork
            request(0, 0, 1'b0, 10'd21, '0, 6);
            request(0, 1, 1'b0, 10'd31, '0, 1);
            begin
                waitUntil(t + 10);
                request(0, 2, 1'b0, 10'd41, '0, 3);
            end
        join
        waitUntil(t + 33);

        // Test 6: MEM_LAT=3 read, then a read aborted by reset, then recovery.
        t = cyc;
        expGnt(1, t + 1, 1, 1'b0, 10'd7, '0);
        expRsp(1, t + 5, 1, 64'd7);
        request(1, 1, 1'b0, 10'd7, '0, 1);
        waitUntil(t + 8);

        t = cyc;
        expGnt(1, t + 1, 1, 1'b0, 10'd9, '0);
        fork
            request(1, 1, 1'b0, 10'd9, '0, 1);
            begin
                waitUntil(t + 3);
                check("t6 busy before reset", 128'(busyV[1]), 128'(1));
                reset = 1'b1;
                #1;
                checkIdle(1, "t6 mid-read reset");
                @(negedge clk);
                reset = 1'b0;
            end
        join
        waitUntil(t + 12);

        t = cyc;
        expGnt(1, t + 1, 1, 1'b0, 10'd9, '0);
        expRsp(1, t + 5, 1, 64'd9);
        request(1, 1, 1'b0, 10'd9, '0, 1);
        waitUntil(t + 8);

        for (int l = 0; l < LANES; l++) begin
            check($sformatf("lane%0d pending grants", l), 128'(gntQ[l].size()), 128'(0));
            check($sformatf("lane%0d pending responses", l), 128'(rspQ[l].size()), 128'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
